mcycle_controller: RTL and testbench
====================================

# mcycle_controller

Sequencing controller for the multicycle variant of the MIPS datapath: a Moore FSM that walks each instruction through fetch, decode, execute, memory and writeback. It drives every mux select, write enable and ALU control of the shared datapath, and stalls on a memory-ready handshake. It also keeps a retired-instruction counter for bring-up and CPI measurement. It sits beside the datapath in the core top level, taking `op`/`funct` from the instruction register and `zero` from the ALU.

## Interface
- `CNT_W`, default 32: width of the retired-instruction counter.
- `clk`  in  1  clock; all state changes on its rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `op`  in  6  instruction opcode field, from the instruction register.
- `funct`  in  6  R-type function field.
- `zero`  in  1  ALU zero flag.
- `mem_ready`  in  1  memory completed the current access this cycle.
- `memreq`  out  1  memory access request.
- `memwrite`  out  1  store strobe.
- `iord`  out  1  address select: 0 = PC, 1 = ALUOut.
- `irwrite`  out  1  instruction register load.
- `pcen`  out  1  PC load; equals `pcwrite | (branch & zero)`.
- `pcsrc`  out  2  PC source: 00 = ALU result, 01 = ALUOut, 10 = jump target.
- `alusrca`  out  1  ALU A source: 0 = PC, 1 = register A.
- `alusrcb`  out  2  ALU B source: 00 = register B, 01 = constant 4, 10 = SignImm, 11 = SignImm<<2.
- `alucontrol`  out  3  ALU operation code.
- `regdst`  out  1  write register: 0 = rt, 1 = rd.
- `memtoreg`  out  1  write data: 0 = ALUOut, 1 = Data register.
- `regwrite`  out  1  register file write enable.
- `illegal`  out  1  one-cycle pulse in DECODE when the opcode is unsupported.
- `instret`  out  CNT_W  count of retired instructions.

## Operation
- Supported opcodes: R-type 000000, lw 100011, sw 101011, beq 000100, addi 001000, j 000010.
- States and transitions:
  - FETCH: stays while `mem_ready`=0; goes to DECODE when `mem_ready`=1.
  - DECODE: lw/sw → MEMADR; R-type → EXECUTE; beq → BRANCH; addi → ADDIEXEC; j → JUMP; any other opcode → FETCH with `illegal`=1.
  - MEMADR: lw → MEMRD; sw → MEMWR.
  - MEMRD: waits on `mem_ready`, then → MEMWB.
  - MEMWR: waits on `mem_ready`, then → FETCH.
  - EXECUTE → ALUWB; ADDIEXEC → ADDIWB.
  - MEMWB, ALUWB, ADDIWB, BRANCH, JUMP → FETCH.
- Outputs are a function of state only, except where `mem_ready`/`zero` are noted. Any signal not listed for a state is 0.
  - FETCH: `memreq`=1, `alusrcb`=01, aluop=00; `irwrite`=`pcwrite`=`mem_ready`.
  - DECODE: `alusrcb`=11, aluop=00 (computes the branch target).
  - MEMADR, ADDIEXEC: `alusrca`=1, `alusrcb`=10, aluop=00.
  - MEMRD: `memreq`=1, `iord`=1.
  - MEMWR: `memreq`=1, `iord`=1, `memwrite`=1, held until `mem_ready`.
  - EXECUTE: `alusrca`=1, aluop=10.
  - ALUWB: `regdst`=1, `regwrite`=1.
  - MEMWB: `memtoreg`=1, `regwrite`=1.
  - ADDIWB: `regwrite`=1.
  - BRANCH: `alusrca`=1, aluop=01, `pcsrc`=01, branch=1.
  - JUMP: `pcsrc`=10, `pcwrite`=1.
- ALU decode:
  - aluop 00 → 010 (add); aluop 01 → 110 (subtract).
  - aluop 10, by funct: 100000 → 010, 100010 → 110, 100100 → 000, 100101 → 001, 101010 → 111; any other funct → 010.
- Retirement: `instret` increments by 1, wrapping modulo 2^CNT_W, on the final cycle of each instruction. Final states are MEMWB, ALUWB, ADDIWB, BRANCH, JUMP, and MEMWR when `mem_ready`=1. Illegal opcodes do not retire.

## Timing
- While `reset`=0: state = FETCH, `instret`=0, and `memreq`, `irwrite`, `pcen`, `regwrite`, `memwrite` forced to 0. All other outputs take their FETCH values.
- The first FETCH request is issued in the cycle after `reset` deasserts.
- Reset asserted mid-instruction aborts it immediately; no partial writeback follows.
- Cycles per instruction with `mem_ready` held at 1: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3, illegal 2. Each memory wait cycle adds 1.
- `pcen` in BRANCH follows `zero` combinationally in the same cycle.
- `mem_ready` is ignored in states that do not drive `memreq`.

## Structure
- Shared package `mcycle_pkg`: state encoding (4-bit enum), opcode constants, funct constants, aluop codes, alucontrol codes.
- One sub-module `alu_decoder`, combinational (aluop, funct → alucontrol).
- The state register and `instret` are the only flops.

## Test plan
- Reset, then deassert with `mem_ready`=1 and op=100011 (lw) → state sequence FETCH, DECODE, MEMADR, MEMRD, MEMWB; `regwrite`=1 and `memtoreg`=1 in cycle 5; `instret` 0 → 1.
- sw with `mem_ready` low for 3 cycles in MEMWR → `memwrite`=1 held 4 cycles, then FETCH; exactly one retire.
- beq with `zero`=1, then `zero`=0 → `pcen`=1 with `pcsrc`=01 in the first case; `pcen`=0 in the second; each takes 3 cycles.
- R-type sweep of funct 100000/100010/100100/100101/101010/111111 → `alucontrol` 010/110/000/001/111/010 in EXECUTE.
- op=111111 → `illegal` pulses for 1 cycle in DECODE, back to FETCH, `instret` unchanged.
- Reset asserted in MEMRD → `memreq`=0 at once, no `regwrite`; fetch restarts after release.

Source files
------------

// File: rtl/mcycle_pkg.sv
// mcycle_pkg: shared types and constants for the multicycle MIPS controller.
//   state_t    : 4-bit FSM state encoding
//   OP_*       : supported opcodes
//   FUNCT_*    : R-type function fields recognised by the ALU decoder
//   aluop_t    : controller-to-ALU-decoder operation class
//   ALUC_*     : ALU operation codes driven on alucontrol
package mcycle_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMRD    = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWR    = 4'd5,
        S_EXECUTE  = 4'd6,
        S_ALUWB    = 4'd7,
        S_BRANCH   = 4'd8,
        S_ADDIEXEC = 4'd9,
        S_ADDIWB   = 4'd10,
        S_JUMP     = 4'd11
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] FUNCT_ADD = 6'b100000;
    localparam logic [5:0] FUNCT_SUB = 6'b100010;
    localparam logic [5:0] FUNCT_AND = 6'b100100;
    localparam logic [5:0] FUNCT_OR  = 6'b100101;
    localparam logic [5:0] FUNCT_SLT = 6'b101010;

    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_FUNCT = 2'b10
    } aluop_t;

    localparam logic [2:0] ALUC_AND = 3'b000;
    localparam logic [2:0] ALUC_OR  = 3'b001;
    localparam logic [2:0] ALUC_ADD = 3'b010;
    localparam logic [2:0] ALUC_SUB = 3'b110;
    localparam logic [2:0] ALUC_SLT = 3'b111;

endpackage

// File: rtl/alu_decoder.sv
// alu_decoder: combinational translation of the controller's aluop class and
// the R-type funct field into the ALU operation code.
//   aluop      in  2  operation class from the controller
//   funct      in  6  R-type function field
//   alucontrol out 3  ALU operation code
module alu_decoder
    import mcycle_pkg::*;
(
    input  aluop_t      aluop,
    input  logic [5:0]  funct,
    output logic [2:0]  alucontrol
);

    always_comb begin
        alucontrol = ALUC_ADD;
        case (aluop)
            ALUOP_ADD: alucontrol = ALUC_ADD;
            ALUOP_SUB: alucontrol = ALUC_SUB;
            ALUOP_FUNCT: begin
                case (funct)
                    FUNCT_ADD: alucontrol = ALUC_ADD;
                    FUNCT_SUB: alucontrol = ALUC_SUB;
                    FUNCT_AND: alucontrol = ALUC_AND;
                    FUNCT_OR:  alucontrol = ALUC_OR;
                    FUNCT_SLT: alucontrol = ALUC_SLT;
                    // unknown funct falls back to add so the datapath stays benign
                    default:   alucontrol = ALUC_ADD;
                endcase
            end
            default: alucontrol = ALUC_ADD;
        endcase
    end

endmodule

// File: rtl/mcycle_controller.sv
// mcycle_controller: Moore sequencing FSM for the multicycle MIPS datapath,
// with a retired-instruction counter.
//   clk, reset (async, active-low)
//   op, funct, zero, mem_ready           : inputs from IR, ALU and memory
//   memreq, memwrite, iord, irwrite, pcen, pcsrc, alusrca, alusrcb,
//   alucontrol, regdst, memtoreg, regwrite: datapath controls
//   illegal : one-cycle pulse in DECODE for an unsupported opcode
//   instret : retired-instruction count, wraps modulo 2^CNT_W
//
//   state    | meaning
//   FETCH    | read instruction at PC, PC <= PC+4 when memory is ready
//   DECODE   | register read, branch target into ALUOut
//   MEMADR   | effective address for lw/sw
//   MEMRD    | load data read, waits on mem_ready
//   MEMWB    | load writeback (retires lw)
//   MEMWR    | store, held until mem_ready (retires sw)
//   EXECUTE  | R-type ALU operation
//   ALUWB    | R-type writeback (retires)
//   BRANCH   | beq compare, PC <= target if zero (retires)
//   ADDIEXEC | addi ALU operation
//   ADDIWB   | addi writeback (retires)
//   JUMP     | PC <= jump target (retires)
module mcycle_controller
    import mcycle_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [5:0]       op,
    input  logic [5:0]       funct,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             memreq,
    output logic             memwrite,
    output logic             iord,
    output logic             irwrite,
    output logic             pcen,
    output logic [1:0]       pcsrc,
    output logic             alusrca,
    output logic [1:0]       alusrcb,
    output logic [2:0]       alucontrol,
    output logic             regdst,
    output logic             memtoreg,
    output logic             regwrite,
    output logic             illegal,
    output logic [CNT_W-1:0] instret
);

    state_t state;
    state_t state_next;
    aluop_t aluop;
    logic   retire;

    logic   memreq_s;
    logic   memwrite_s;
    logic   irwrite_s;
    logic   regwrite_s;
    logic   pcwrite_s;
    logic   branch_s;

    always_comb begin
        state_next = state;
        illegal    = 1'b0;
        case (state)
            S_FETCH:    if (mem_ready) state_next = S_DECODE;
            S_DECODE: begin
                case (op)
                    OP_LW, OP_SW: state_next = S_MEMADR;
                    OP_RTYPE:     state_next = S_EXECUTE;
                    OP_BEQ:       state_next = S_BRANCH;
                    OP_ADDI:      state_next = S_ADDIEXEC;
                    OP_J:         state_next = S_JUMP;
                    default: begin
                        state_next = S_FETCH;
                        illegal    = 1'b1;
                    end
                endcase
            end
            S_MEMADR:   state_next = (op == OP_LW) ? S_MEMRD : S_MEMWR;
            S_MEMRD:    if (mem_ready) state_next = S_MEMWB;
            S_MEMWR:    if (mem_ready) state_next = S_FETCH;
            S_EXECUTE:  state_next = S_ALUWB;
            S_ADDIEXEC: state_next = S_ADDIWB;
            S_MEMWB, S_ALUWB, S_ADDIWB, S_BRANCH, S_JUMP: state_next = S_FETCH;
            default:    state_next = S_FETCH;
        endcase
    end

    always_comb begin
        case (state)
            S_MEMWB, S_ALUWB, S_ADDIWB, S_BRANCH, S_JUMP: retire = 1'b1;
            S_MEMWR: retire = mem_ready;
            default: retire = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= S_FETCH;
            instret <= '0;
        end else begin
            state <= state_next;
            if (retire) instret <= instret + CNT_W'(1);
        end
    end

    always_comb begin
        memreq_s   = 1'b0;
        memwrite_s = 1'b0;
        iord       = 1'b0;
        irwrite_s  = 1'b0;
        pcwrite_s  = 1'b0;
        branch_s   = 1'b0;
        pcsrc      = 2'b00;
        alusrca    = 1'b0;
        alusrcb    = 2'b00;
        aluop      = ALUOP_ADD;
        regdst     = 1'b0;
        memtoreg   = 1'b0;
        regwrite_s = 1'b0;
        case (state)
            S_FETCH: begin
                memreq_s  = 1'b1;
                alusrcb   = 2'b01;
                irwrite_s = mem_ready;
                pcwrite_s = mem_ready;
            end
            S_DECODE:   alusrcb = 2'b11;
            S_MEMADR, S_ADDIEXEC: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
            end
            S_MEMRD: begin
                memreq_s = 1'b1;
                iord     = 1'b1;
            end
            S_MEMWR: begin
                memreq_s   = 1'b1;
                iord       = 1'b1;
                memwrite_s = 1'b1;
            end
            S_EXECUTE: begin
                alusrca = 1'b1;
                aluop   = ALUOP_FUNCT;
            end
            S_ALUWB: begin
                regdst     = 1'b1;
                regwrite_s = 1'b1;
            end
            S_MEMWB: begin
                memtoreg   = 1'b1;
                regwrite_s = 1'b1;
            end
            S_ADDIWB:   regwrite_s = 1'b1;
            S_BRANCH: begin
                alusrca  = 1'b1;
                aluop    = ALUOP_SUB;
                pcsrc    = 2'b01;
                branch_s = 1'b1;
            end
            S_JUMP: begin
                pcsrc     = 2'b10;
                pcwrite_s = 1'b1;
            end
            default: ;
        endcase
    end

    // Reset holds the state at FETCH, so only the side-effecting strobes need
    // masking; the mux selects already show their FETCH values.
    assign memreq   = reset & memreq_s;
    assign memwrite = reset & memwrite_s;
    assign irwrite  = reset & irwrite_s;
    assign regwrite = reset & regwrite_s;
    assign pcen     = reset & (pcwrite_s | (branch_s & zero));

    alu_decoder u_alu_decoder (
        .aluop      (aluop),
        .funct      (funct),
        .alucontrol (alucontrol)
    );

endmodule

// File: tb/tb_mcycle_controller.sv
// Testbench for mcycle_controller: per-cycle table of inputs and expected
// outputs, plus hand sequences for a stalled store and counter wrap.
module tb_mcycle_controller;
    import mcycle_pkg::*;

    logic       clk;
    logic       reset;
    logic [5:0] op;
    logic [5:0] funct;
    logic       zero;
    logic       mem_ready;

    logic        memreq, memwrite, iord, irwrite, pcen;
    logic [1:0]  pcsrc;
    logic        alusrca;
    logic [1:0]  alusrcb;
    logic [2:0]  alucontrol;
    logic        regdst, memtoreg, regwrite, illegal;
    logic [31:0] instret;

    logic        reset2;
    logic [5:0]  op2;
    logic        mem_ready2;
    logic        memreq2, memwrite2, iord2, irwrite2, pcen2;
    logic [1:0]  pcsrc2;
    logic        alusrca2;
    logic [1:0]  alusrcb2;
    logic [2:0]  alucontrol2;
    logic        regdst2, memtoreg2, regwrite2, illegal2;
    logic [1:0]  instret2;

    mcycle_controller #(.CNT_W(32)) dut (
        .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero),
        .mem_ready(mem_ready), .memreq(memreq), .memwrite(memwrite), .iord(iord),
        .irwrite(irwrite), .pcen(pcen), .pcsrc(pcsrc), .alusrca(alusrca),
        .alusrcb(alusrcb), .alucontrol(alucontrol), .regdst(regdst),
        .memtoreg(memtoreg), .regwrite(regwrite), .illegal(illegal),
        .instret(instret)
    );

    mcycle_controller #(.CNT_W(2)) dut2 (
        .clk(clk), .reset(reset2), .op(op2), .funct(funct), .zero(zero),
        .mem_ready(mem_ready2), .memreq(memreq2), .memwrite(memwrite2), .iord(iord2),
        .irwrite(irwrite2), .pcen(pcen2), .pcsrc(pcsrc2), .alusrca(alusrca2),
        .alusrcb(alusrcb2), .alucontrol(alucontrol2), .regdst(regdst2),
        .memtoreg(memtoreg2), .regwrite(regwrite2), .illegal(illegal2),
        .instret(instret2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {memreq, memwrite, iord, irwrite, pcen, pcsrc, alusrca, alusrcb,
    //  alucontrol, regdst, memtoreg, regwrite, illegal}
    logic [16:0] act;
    assign act = {memreq, memwrite, iord, irwrite, pcen, pcsrc, alusrca, alusrcb,
                  alucontrol, regdst, memtoreg, regwrite, illegal};

    localparam logic [16:0] R_RST  = 17'b0_0_0_0_0_00_0_01_010_0_0_0_0;
    localparam logic [16:0] F_RDY  = 17'b1_0_0_1_1_00_0_01_010_0_0_0_0;
    localparam logic [16:0] F_WT   = 17'b1_0_0_0_0_00_0_01_010_0_0_0_0;
    localparam logic [16:0] DEC    = 17'b0_0_0_0_0_00_0_11_010_0_0_0_0;
    localparam logic [16:0] DEC_IL = 17'b0_0_0_0_0_00_0_11_010_0_0_0_1;
    localparam logic [16:0] MADR   = 17'b0_0_0_0_0_00_1_10_010_0_0_0_0;
    localparam logic [16:0] MRD    = 17'b1_0_1_0_0_00_0_00_010_0_0_0_0;
    localparam logic [16:0] MWR    = 17'b1_1_1_0_0_00_0_00_010_0_0_0_0;
    localparam logic [16:0] MWB    = 17'b0_0_0_0_0_00_0_00_010_0_1_1_0;
    localparam logic [16:0] AWB    = 17'b0_0_0_0_0_00_0_00_010_1_0_1_0;
    localparam logic [16:0] IWB    = 17'b0_0_0_0_0_00_0_00_010_0_0_1_0;
    localparam logic [16:0] BR_T   = 17'b0_0_0_0_1_01_1_00_110_0_0_0_0;
    localparam logic [16:0] BR_N   = 17'b0_0_0_0_0_01_1_00_110_0_0_0_0;
    localparam logic [16:0] JMP    = 17'b0_0_0_0_1_10_0_00_010_0_0_0_0;

    function automatic logic [16:0] ex(input logic [2:0] c);
        return {10'b0000000100, c, 4'b0000};
    endfunction

    typedef struct {
        logic        rst;
        logic [5:0]  op;
        logic [5:0]  funct;
        logic        zero;
        logic        mr;
        logic [16:0] sig;
        logic [31:0] cnt;
    } vec_t;

    vec_t vecs[$];
    int   checks   = 0;
    int   failures = 0;

    task automatic v(input logic r, input logic [5:0] o, input logic [5:0] f,
                     input logic z, input logic m, input logic [16:0] s,
                     input logic [31:0] c);
        vec_t t;
        t.rst = r; t.op = o; t.funct = f; t.zero = z; t.mr = m; t.sig = s; t.cnt = c;
        vecs.push_back(t);
    endtask

    task automatic check(input string name, input int idx,
                         input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s [%0d]: got %b expected %b", name, idx, got, exp);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    logic [5:0] sweep_f [6];
    logic [2:0] sweep_c [6];
    int         n_wr;

    initial begin
        sweep_f = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010, 6'b111111};
        sweep_c = '{3'b010,    3'b110,    3'b000,    3'b001,    3'b111,    3'b010};

        // reset: strobes masked, FETCH selects visible
        v(0, OP_LW, 6'd0, 0, 1, R_RST, 0);
        v(0, OP_LW, 6'd0, 0, 0, R_RST, 0);
        // lw with one memory wait in MEMRD
        v(1, OP_LW, 6'd0, 0, 1, F_RDY, 0);
        v(1, OP_LW, 6'd0, 0, 0, DEC,   0);
        v(1, OP_LW, 6'd0, 0, 0, MADR,  0);
        v(1, OP_LW, 6'd0, 0, 0, MRD,   0);
        v(1, OP_LW, 6'd0, 0, 1, MRD,   0);
        v(1, OP_LW, 6'd0, 0, 0, MWB,   0);
        // sw with a fetch stall and three store stalls
        v(1, OP_SW, 6'd0, 0, 0, F_WT,  1);
        v(1, OP_SW, 6'd0, 0, 1, F_RDY, 1);
        v(1, OP_SW, 6'd0, 0, 1, DEC,   1);
        v(1, OP_SW, 6'd0, 0, 1, MADR,  1);
        v(1, OP_SW, 6'd0, 0, 0, MWR,   1);
        v(1, OP_SW, 6'd0, 0, 0, MWR,   1);
        v(1, OP_SW, 6'd0, 0, 0, MWR,   1);
        v(1, OP_SW, 6'd0, 0, 1, MWR,   1);
        // beq taken then not taken
        v(1, OP_BEQ, 6'd0, 1, 1, F_RDY, 2);
        v(1, OP_BEQ, 6'd0, 1, 1, DEC,   2);
        v(1, OP_BEQ, 6'd0, 1, 1, BR_T,  2);
        v(1, OP_BEQ, 6'd0, 0, 1, F_RDY, 3);
        v(1, OP_BEQ, 6'd0, 0, 1, DEC,   3);
        v(1, OP_BEQ, 6'd0, 0, 1, BR_N,  3);
        // R-type funct sweep
        for (int i = 0; i < 6; i++) begin
            v(1, OP_RTYPE, sweep_f[i], 0, 1, F_RDY,          32'(4 + i));
            v(1, OP_RTYPE, sweep_f[i], 0, 1, DEC,            32'(4 + i));
            v(1, OP_RTYPE, sweep_f[i], 0, 1, ex(sweep_c[i]), 32'(4 + i));
            v(1, OP_RTYPE, sweep_f[i], 0, 0, AWB,            32'(4 + i));
        end
        // addi, j
        v(1, OP_ADDI, 6'd0, 0, 1, F_RDY, 10);
        v(1, OP_ADDI, 6'd0, 0, 1, DEC,   10);
        v(1, OP_ADDI, 6'd0, 0, 1, MADR,  10);
        v(1, OP_ADDI, 6'd0, 0, 1, IWB,   10);
        v(1, OP_J,    6'd0, 0, 1, F_RDY, 11);
        v(1, OP_J,    6'd0, 0, 1, DEC,   11);
        v(1, OP_J,    6'd0, 0, 1, JMP,   11);
        // illegal opcode: no retire
        v(1, 6'b111111, 6'd0, 0, 1, F_RDY,  12);
        v(1, 6'b111111, 6'd0, 0, 1, DEC_IL, 12);
        // lw aborted by reset in MEMRD
        v(1, OP_LW, 6'd0, 0, 1, F_RDY, 12);
        v(1, OP_LW, 6'd0, 0, 1, DEC,   12);
        v(1, OP_LW, 6'd0, 0, 1, MADR,  12);
        v(1, OP_LW, 6'd0, 0, 0, MRD,   12);
        v(0, OP_LW, 6'd0, 0, 0, R_RST, 0);
        v(0, OP_LW, 6'd0, 0, 1, R_RST, 0);
        v(1, OP_LW, 6'd0, 0, 1, F_RDY, 0);
        v(1, OP_LW, 6'd0, 0, 1, DEC,   0);
        v(1, OP_LW, 6'd0, 0, 1, MADR,  0);
        v(1, OP_LW, 6'd0, 0, 1, MRD,   0);
        v(1, OP_LW, 6'd0, 0, 1, MWB,   0);

        reset = 1'b0; op = OP_LW; funct = 6'd0; zero = 1'b0; mem_ready = 1'b0;
        reset2 = 1'b0; op2 = OP_J; mem_ready2 = 1'b1;

        foreach (vecs[i]) begin
            @(negedge clk);
            reset = vecs[i].rst; op = vecs[i].op; funct = vecs[i].funct;
            zero = vecs[i].zero; mem_ready = vecs[i].mr;
            #1;
            check("outputs", i, 32'(act), 32'(vecs[i].sig));
            check("instret", i, instret, vecs[i].cnt);
        end

        // stalled store: memwrite held for every MEMWR cycle, single retire
        @(negedge clk); op = OP_SW; mem_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        n_wr = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            mem_ready = (k >= 2);
            #1;
            if (!memwrite) break;
            n_wr++;
        end
        check("sw_memwrite_cycles", 0, 32'(n_wr), 32'd3);
        check("sw_retire", 0, instret, 32'd2);
        check("sw_back_to_fetch", 0, 32'(act), 32'(F_RDY));

        // 2-bit counter wraps after four jumps
        @(negedge clk); reset2 = 1'b1;
        for (int ins = 1; ins <= 5; ins++) begin
            repeat (3) @(negedge clk);
            #1;
            check("instret_wrap", ins, 32'(instret2), 32'(ins % 4));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
